// File: rtl/deserialize.sv
// Serial-to-parallel converter: assembles 8-bit frames MSB- or LSB-first
// and holds each byte under a valid/ready handshake until it is accepted.
module deserialize (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dir,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] sr, sr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          dir_q, dir_nxt;
  logic [DW-1:0] out_nxt;
  logic          out_valid_nxt;
  logic          busy_nxt;
  logic          overrun_nxt;
  logic [DW-1:0] shifted;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      dir_q     <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      cnt       <= cnt_nxt;
      dir_q     <= dir_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
      overrun   <= overrun_nxt;
    end
  end

  // Next-state and next-output logic; an accepted start always restarts the frame
  always_comb begin
    state_nxt     = state;
    sr_nxt        = sr;
    cnt_nxt       = cnt;
    dir_nxt       = dir_q;
    out_nxt       = out;
    out_valid_nxt = out_valid;
    overrun_nxt   = overrun;
    shifted       = dir_q ? {bit_in, sr[DW-1:1]} : {sr[DW-2:0], bit_in};

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = RECV;
          cnt_nxt     = '0;
          sr_nxt      = '0;
          dir_nxt     = dir;
          overrun_nxt = 1'b0;
        end else if (bit_valid) begin
          overrun_nxt = 1'b1;
        end
      end
      RECV: begin
        if (start) begin
          cnt_nxt     = '0;
          sr_nxt      = '0;
          dir_nxt     = dir;
          overrun_nxt = 1'b0;
        end else if (bit_valid) begin
          sr_nxt  = shifted;
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(DW - 1)) begin
            state_nxt     = HOLD;
            out_nxt       = shifted;
            out_valid_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          out_valid_nxt = 1'b0;
          if (start) begin
            state_nxt   = RECV;
            cnt_nxt     = '0;
            sr_nxt      = '0;
            dir_nxt     = dir;
            overrun_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
            if (bit_valid) overrun_nxt = 1'b1;
          end
        end else if (bit_valid) begin
          overrun_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt     = IDLE;
        out_valid_nxt = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt == RECV);
  end

endmodule

// File: tb/tb_deserialize.sv
// Scoreboard bench for deserialize: directed frames push expected bytes,
// a negedge monitor pops and compares on every accepted handshake.
module tb_deserialize;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       dir;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       overrun;

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_q[$];

  deserialize dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dir       (dir),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, want);
  endtask

  // Inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    step();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic begin_frame(input logic d);
    start = 1'b1;
    dir   = d;
    step();
    start = 1'b0;
  endtask

  // Scoreboard monitor: a byte is consumed when valid and ready meet
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected: got 0x%02h expected no byte", out);
      end else begin
        check("sb_byte", out, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] bits_a;
    logic [7:0] bits_b;
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; bit_in = 1'b0;
    bit_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    check("rst_out", out, 8'h00);
    check("rst_out_valid", 8'(out_valid), 8'h00);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_overrun", 8'(overrun), 8'h00);
    rst_n = 1'b1;

    // MSB-first 0x12 on consecutive cycles
    begin_frame(1'b0);
    check("msb_busy", 8'(busy), 8'h01);
    exp_q.push_back(8'h12);
    bits_a = 8'b0001_0010;
    for (int i = 7; i >= 0; i--) send_bit(bits_a[i]);
    check("msb_out", out, 8'h12);
    check("msb_valid", 8'(out_valid), 8'h01);
    check("msb_busy_after", 8'(busy), 8'h00);
    step();
    check("msb_valid_drop", 8'(out_valid), 8'h00);

    // LSB-first 0x12 with idle gaps, held in HOLD afterwards
    out_ready = 1'b0;
    begin_frame(1'b1);
    bits_b = 8'b0001_0010;
    for (int i = 0; i < 8; i++) begin
      send_bit(bits_b[i]);
      if (i < 7) begin
        for (int g = 0; g <= (i % 3); g++) step();
        check("lsb_no_valid", 8'(out_valid), 8'h00);
      end
    end
    check("lsb_out", out, 8'h12);
    check("lsb_valid", 8'(out_valid), 8'h01);

    // HOLD stalled with stray bits, then accept with a new start
    exp_q.push_back(8'h12);
    for (int c = 0; c < 5; c++) begin
      bit_valid = (c == 2);
      bit_in    = 1'b1;
      step();
      bit_valid = 1'b0;
      check("hold_out", out, 8'h12);
    end
    check("hold_valid", 8'(out_valid), 8'h01);
    check("hold_overrun", 8'(overrun), 8'h01);
    out_ready = 1'b1;
    begin_frame(1'b0);
    check("hold_accept_busy", 8'(busy), 8'h01);
    check("hold_accept_valid", 8'(out_valid), 8'h00);
    check("hold_accept_overrun", 8'(overrun), 8'h00);

    // Abort after 5 bits, restart LSB-first with 0xFF
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    begin_frame(1'b1);
    check("abort_busy", 8'(busy), 8'h01);
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    check("abort_no_early_valid", 8'(out_valid), 8'h00);
    send_bit(1'b1);
    check("abort_out", out, 8'hFF);
    step();

    // 8th bit colliding with start: start wins
    begin_frame(1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    start = 1'b1; dir = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    step();
    start = 1'b0; bit_valid = 1'b0;
    check("collide_valid", 8'(out_valid), 8'h00);
    check("collide_busy", 8'(busy), 8'h01);
    exp_q.push_back(8'h3C);
    bits_a = 8'h3C;
    for (int i = 7; i >= 1; i--) send_bit(bits_a[i]);
    check("collide_cnt_zero", 8'(out_valid), 8'h00);
    send_bit(bits_a[0]);
    check("collide_out", out, 8'h3C);
    step();

    // Reset mid-frame, then a full 0xA5 frame right after release
    begin_frame(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    step();
    check("midrst_out", out, 8'h00);
    check("midrst_valid", 8'(out_valid), 8'h00);
    check("midrst_busy", 8'(busy), 8'h00);
    check("midrst_overrun", 8'(overrun), 8'h00);
    rst_n = 1'b1;
    begin_frame(1'b0);
    check("post_rst_busy", 8'(busy), 8'h01);
    exp_q.push_back(8'hA5);
    bits_b = 8'hA5;
    for (int i = 7; i >= 0; i--) send_bit(bits_b[i]);
    check("post_rst_out", out, 8'hA5);
    step();

    // Stray bit in IDLE sets overrun without touching out; start clears it
    send_bit(1'b0);
    check("idle_overrun", 8'(overrun), 8'h01);
    check("idle_out_kept", out, 8'hA5);
    check("idle_busy", 8'(busy), 8'h00);
    begin_frame(1'b0);
    check("idle_overrun_clr", 8'(overrun), 8'h00);

    step(); step();
    check("sb_drained", 8'(exp_q.size()), 8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
